// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, standard capture constants and count-width helper
package jtag_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR_SCAN   = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR_SCAN   = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_e;
  localparam logic       BYPASS_CAPTURE = 1'b0;
  localparam logic [1:0] IR_CAPTURE     = 2'b01;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/jtag_data_register_if.sv
// jtag_data_register_if: TAP-decode side controls and register outputs
interface jtag_data_register_if #(parameter int WIDTH = 8);
  logic                                 Select;
  logic                                 CaptureDR;
  logic                                 ShiftDR;
  logic                                 UpdateDR;
  logic                                 TDI;
  logic [WIDTH-1:0]                     ParallelIn;
  logic                                 TDO;
  logic [WIDTH-1:0]                     ParallelOut;
  logic [jtag_pkg::cnt_w(WIDTH)-1:0]    ShiftCount;
  logic                                 ShiftFull;
  modport master (
    output Select, CaptureDR, ShiftDR, UpdateDR, TDI, ParallelIn,
    input  TDO, ParallelOut, ShiftCount, ShiftFull
  );
  modport slave (
    input  Select, CaptureDR, ShiftDR, UpdateDR, TDI, ParallelIn,
    output TDO, ParallelOut, ShiftCount, ShiftFull
  );
endinterface

// File: rtl/jtag_update_latch.sv
// jtag_update_latch: enabled register with sync reset, shared by DR and IR update stages
module jtag_update_latch #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;
  // load on enable, otherwise hold
  always_comb q_d = en ? d : q_q;
  // state register with sync reset
  always_ff @(posedge clk) q_q <= rst ? RST_VAL : q_d;
  assign q = q_q;
endmodule

// File: rtl/jtag_data_register.sv
// jtag_data_register: capture/shift chain with update latch and saturating shift counter
module jtag_data_register import jtag_pkg::*; #(
  parameter int               WIDTH         = 8,
  parameter bit               CAPTURE_FIXED = 1'b0,
  parameter logic [WIDTH-1:0] CAPTURE_VALUE = '0,
  parameter logic [WIDTH-1:0] UPDATE_RESET  = '0
) (
  input logic ClockDR,
  input logic Reset,
  jtag_data_register_if.slave bus
);
  localparam int               CW      = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] STG_RST = CAPTURE_FIXED ? CAPTURE_VALUE : '0;
  logic [WIDTH-1:0] stage_q, stage_d, cap_val, shifted;
  logic [WIDTH:0]   shift_ext;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  // next stage and count: capture beats shift; deselected register holds
  always_comb begin
    cap_val   = CAPTURE_FIXED ? CAPTURE_VALUE : bus.ParallelIn;
    shift_ext = {bus.TDI, stage_q};
    shifted   = shift_ext[WIDTH:1];
    full      = count_q == CW'(WIDTH);
    stage_d   = !bus.Select ? stage_q : bus.CaptureDR ? cap_val : bus.ShiftDR ? shifted : stage_q;
    count_d   = !bus.Select ? count_q : bus.CaptureDR ? '0 :
                (bus.ShiftDR && !full) ? count_q + CW'(1) : count_q;
  end
  // stage and counter registers, reset discards any partial scan
  always_ff @(posedge ClockDR) begin
    stage_q <= Reset ? STG_RST : stage_d;
    count_q <= Reset ? '0 : count_d;
  end
  jtag_update_latch #(.WIDTH(WIDTH), .RST_VAL(UPDATE_RESET)) u_upd (
    .clk (ClockDR),
    .rst (Reset),
    .en  (bus.Select && bus.UpdateDR),
    .d   (stage_q),
    .q   (bus.ParallelOut)
  );
  assign bus.TDO        = stage_q[0];
  assign bus.ShiftCount = count_q;
  assign bus.ShiftFull  = full;
endmodule

// File: tb/tb_jtag_data_register.sv
// tb_jtag_data_register: directed checks of bypass and 8-bit data register configurations
module tb_jtag_data_register;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  always #5 clk = ~clk;

  jtag_data_register_if #(.WIDTH(1)) bif ();
  jtag_data_register_if #(.WIDTH(8)) dif ();

  jtag_data_register #(.WIDTH(1), .CAPTURE_FIXED(1'b1), .CAPTURE_VALUE(1'b0), .UPDATE_RESET(1'b0)) u_byp (
    .ClockDR (clk),
    .Reset   (rst),
    .bus     (bif.slave)
  );
  jtag_data_register #(.WIDTH(8), .CAPTURE_FIXED(1'b0), .CAPTURE_VALUE(8'h00), .UPDATE_RESET(8'h00)) u_dr (
    .ClockDR (clk),
    .Reset   (rst),
    .bus     (dif.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_dr();
    dif.Select = 1'b0; dif.CaptureDR = 1'b0; dif.ShiftDR = 1'b0; dif.UpdateDR = 1'b0; dif.TDI = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (dif.TDO !== 1'b0) begin errs++; $display("FAIL reset_tdo got %b want 0", dif.TDO); end
    vecs++; if (dif.ParallelOut !== 8'h00) begin errs++; $display("FAIL reset_pout got %h want 00", dif.ParallelOut); end
    vecs++; if (dif.ShiftCount !== 4'd0) begin errs++; $display("FAIL reset_count got %0d want 0", dif.ShiftCount); end
    vecs++; if (dif.ShiftFull !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", dif.ShiftFull); end
    vecs++; if (bif.TDO !== 1'b0) begin errs++; $display("FAIL reset_byp_tdo got %b want 0", bif.TDO); end
    vecs++; if (bif.ShiftFull !== 1'b0) begin errs++; $display("FAIL reset_byp_full got %b want 0", bif.ShiftFull); end
  endtask

  task automatic test_bypass();
    bif.Select = 1'b1; bif.CaptureDR = 1'b1; bif.TDI = 1'b1;
    step();
    vecs++; if (bif.TDO !== 1'b0) begin errs++; $display("FAIL byp_cap_tdo got %b want 0", bif.TDO); end
    vecs++; if (bif.ShiftCount !== 1'd0) begin errs++; $display("FAIL byp_cap_count got %0d want 0", bif.ShiftCount); end
    bif.CaptureDR = 1'b0; bif.ShiftDR = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++; if (bif.TDO !== 1'b1) begin errs++; $display("FAIL byp_shift%0d_tdo got %b want 1", i, bif.TDO); end
      vecs++; if (bif.ShiftCount !== 1'd1) begin errs++; $display("FAIL byp_shift%0d_count got %0d want 1", i, bif.ShiftCount); end
      vecs++; if (bif.ShiftFull !== 1'b1) begin errs++; $display("FAIL byp_shift%0d_full got %b want 1", i, bif.ShiftFull); end
    end
    bif.ShiftDR = 1'b0; bif.Select = 1'b0;
  endtask

  task automatic test_shift8();
    logic [7:0] cap = 8'hA5;
    logic [7:0] tdi = 8'h3C;
    dif.Select = 1'b1; dif.CaptureDR = 1'b1; dif.ParallelIn = cap;
    step();
    dif.CaptureDR = 1'b0; dif.ShiftDR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs++; if (dif.TDO !== cap[i]) begin errs++; $display("FAIL shift8_tdo%0d got %b want %b", i, dif.TDO, cap[i]); end
      vecs++; if (dif.ParallelOut !== 8'h00) begin errs++; $display("FAIL shift8_pout_hold%0d got %h want 00", i, dif.ParallelOut); end
      dif.TDI = tdi[i];
      step();
    end
    vecs++; if (dif.ShiftCount !== 4'd8) begin errs++; $display("FAIL shift8_count got %0d want 8", dif.ShiftCount); end
    vecs++; if (dif.ShiftFull !== 1'b1) begin errs++; $display("FAIL shift8_full got %b want 1", dif.ShiftFull); end
    vecs++; if (dif.TDO !== 1'b0) begin errs++; $display("FAIL shift8_tdo_end got %b want 0", dif.TDO); end
    vecs++; if (dif.ParallelOut !== 8'h00) begin errs++; $display("FAIL shift8_pout_pre got %h want 00", dif.ParallelOut); end
    dif.ShiftDR = 1'b0; dif.UpdateDR = 1'b1;
    step();
    dif.UpdateDR = 1'b0;
    vecs++; if (dif.ParallelOut !== 8'h3C) begin errs++; $display("FAIL shift8_update got %h want 3c", dif.ParallelOut); end
  endtask

  task automatic test_deselect();
    dif.Select = 1'b0; dif.CaptureDR = 1'b1; dif.ShiftDR = 1'b1; dif.UpdateDR = 1'b1;
    dif.ParallelIn = 8'hFF; dif.TDI = 1'b1;
    step();
    dif.CaptureDR = 1'b0; dif.UpdateDR = 1'b0;
    step();
    vecs++; if (dif.ParallelOut !== 8'h3C) begin errs++; $display("FAIL desel_pout got %h want 3c", dif.ParallelOut); end
    vecs++; if (dif.ShiftCount !== 4'd8) begin errs++; $display("FAIL desel_count got %0d want 8", dif.ShiftCount); end
    vecs++; if (dif.TDO !== 1'b0) begin errs++; $display("FAIL desel_tdo got %b want 0", dif.TDO); end
    dif.Select = 1'b1; dif.ShiftDR = 1'b1; dif.TDI = 1'b0;
    step();
    vecs++; if (dif.TDO !== 1'b0) begin errs++; $display("FAIL desel_tdo1 got %b want 0", dif.TDO); end
    step();
    vecs++; if (dif.TDO !== 1'b1) begin errs++; $display("FAIL desel_tdo2 got %b want 1", dif.TDO); end
    idle_dr();
  endtask

  task automatic test_collisions();
    dif.Select = 1'b1; dif.CaptureDR = 1'b1; dif.ShiftDR = 1'b1; dif.ParallelIn = 8'hFF; dif.TDI = 1'b0;
    step();
    vecs++; if (dif.ShiftCount !== 4'd0) begin errs++; $display("FAIL col_cap_count got %0d want 0", dif.ShiftCount); end
    vecs++; if (dif.TDO !== 1'b1) begin errs++; $display("FAIL col_cap_tdo got %b want 1", dif.TDO); end
    dif.CaptureDR = 1'b0; dif.ShiftDR = 1'b0; dif.UpdateDR = 1'b1;
    step();
    vecs++; if (dif.ParallelOut !== 8'hFF) begin errs++; $display("FAIL col_cap_stage got %h want ff", dif.ParallelOut); end
    dif.UpdateDR = 1'b0; dif.CaptureDR = 1'b1; dif.ParallelIn = 8'h81;
    step();
    dif.CaptureDR = 1'b0; dif.ShiftDR = 1'b1; dif.UpdateDR = 1'b1; dif.TDI = 1'b0;
    step();
    vecs++; if (dif.ParallelOut !== 8'h81) begin errs++; $display("FAIL col_upd_pre got %h want 81", dif.ParallelOut); end
    vecs++; if (dif.ShiftCount !== 4'd1) begin errs++; $display("FAIL col_upd_count got %0d want 1", dif.ShiftCount); end
    vecs++; if (dif.TDO !== 1'b0) begin errs++; $display("FAIL col_upd_tdo got %b want 0", dif.TDO); end
    dif.ShiftDR = 1'b0;
    step();
    vecs++; if (dif.ParallelOut !== 8'h40) begin errs++; $display("FAIL col_upd_post got %h want 40", dif.ParallelOut); end
    idle_dr();
  endtask

  task automatic test_saturate();
    logic [11:0] pat = 12'hB59;
    logic [3:0]  exp_cnt;
    logic        exp_tdo;
    dif.Select = 1'b1; dif.CaptureDR = 1'b1; dif.ParallelIn = 8'h00;
    step();
    dif.CaptureDR = 1'b0; dif.ShiftDR = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      dif.TDI = pat[k-1];
      step();
      exp_cnt = (k >= 8) ? 4'd8 : 4'(k);
      exp_tdo = (k >= 8) ? pat[k-8] : 1'b0;
      vecs++; if (dif.ShiftCount !== exp_cnt) begin errs++; $display("FAIL sat_count%0d got %0d want %0d", k, dif.ShiftCount, exp_cnt); end
      vecs++; if (dif.ShiftFull !== (k >= 8)) begin errs++; $display("FAIL sat_full%0d got %b want %b", k, dif.ShiftFull, k >= 8); end
      vecs++; if (dif.TDO !== exp_tdo) begin errs++; $display("FAIL sat_tdo%0d got %b want %b", k, dif.TDO, exp_tdo); end
    end
    idle_dr();
  endtask

  task automatic test_reset_mid();
    dif.Select = 1'b1; dif.CaptureDR = 1'b1; dif.ParallelIn = 8'h3C;
    step();
    dif.CaptureDR = 1'b0; dif.UpdateDR = 1'b1;
    step();
    dif.UpdateDR = 1'b0;
    vecs++; if (dif.ParallelOut !== 8'h3C) begin errs++; $display("FAIL rmid_setup got %h want 3c", dif.ParallelOut); end
    dif.ShiftDR = 1'b1; dif.TDI = 1'b1;
    repeat (3) step();
    vecs++; if (dif.ShiftCount !== 4'd3) begin errs++; $display("FAIL rmid_count3 got %0d want 3", dif.ShiftCount); end
    rst = 1'b1;
    step();
    rst = 1'b0; dif.ShiftDR = 1'b0;
    vecs++; if (dif.ParallelOut !== 8'h00) begin errs++; $display("FAIL rmid_pout got %h want 00", dif.ParallelOut); end
    vecs++; if (dif.ShiftCount !== 4'd0) begin errs++; $display("FAIL rmid_count got %0d want 0", dif.ShiftCount); end
    vecs++; if (dif.ShiftFull !== 1'b0) begin errs++; $display("FAIL rmid_full got %b want 0", dif.ShiftFull); end
    vecs++; if (dif.TDO !== 1'b0) begin errs++; $display("FAIL rmid_tdo got %b want 0", dif.TDO); end
    dif.UpdateDR = 1'b1;
    step();
    vecs++; if (dif.ParallelOut !== 8'h00) begin errs++; $display("FAIL rmid_stage got %h want 00", dif.ParallelOut); end
    idle_dr();
  endtask

  initial begin
    bif.Select = 1'b0; bif.CaptureDR = 1'b0; bif.ShiftDR = 1'b0; bif.UpdateDR = 1'b0; bif.TDI = 1'b0; bif.ParallelIn = 1'b0;
    idle_dr();
    dif.ParallelIn = 8'h00;
    test_reset();
    test_bypass();
    test_shift8();
    test_deselect();
    test_collisions();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
